proc_io_sched: RTL and testbench

- I/O scheduler between the float-processor wrapper's decoded I/O strobes and NCH external sample streams.
- Input side: a 2-deep FIFO per channel buffers valid/ready input samples. The processor's one-hot read strobes pop them, and the selected FIFO head drives the processor input bus.
- Output side: the processor's one-hot write strobes capture the result bus into per-channel valid/ready output registers.
- Sticky underrun/overrun flags report scheduling faults without stalling the processor.

---
 rtl/proc_io_sched_if.sv | 33 +++
 rtl/proc_io_sched.sv | 182 ++++++++++++++++++
 tb/tb_proc_io_sched.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_io_sched_if.sv
// proc_io_sched_if: groups the sample streams, processor strobes and status
// flags of the I/O scheduler. The scheduler uses the slave view, and the
// processor/stream side uses the master view.
interface proc_io_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 19,
  parameter int OW  = 28
);
  logic [NCH*DW-1:0] s_data;
  logic [NCH-1:0]    s_valid;
  logic [NCH-1:0]    s_ready;
  logic [NCH-1:0]    req_in;
  logic [DW-1:0]     io_in;
  logic [NCH-1:0]    out_en;
  logic [OW-1:0]     io_out;
  logic [NCH*OW-1:0] m_data;
  logic [NCH-1:0]    m_valid;
  logic [NCH-1:0]    m_ready;
  logic [NCH-1:0]    underrun;
  logic [NCH-1:0]    overrun;
  logic              sel_err;
  logic              clr_flags;

  modport slave (
    input  s_data, s_valid, req_in, out_en, io_out, m_ready, clr_flags,
    output s_ready, io_in, m_data, m_valid, underrun, overrun, sel_err
  );

  modport master (
    output s_data, s_valid, req_in, out_en, io_out, m_ready, clr_flags,
    input  s_ready, io_in, m_data, m_valid, underrun, overrun, sel_err
  );
endinterface

// File: rtl/proc_io_sched.sv
// proc_io_sched: I/O scheduler between the float processor's decoded I/O
// strobes and NCH external sample streams. Each input channel has a 2-deep
// FIFO that is popped by a one-hot read strobe. Each output channel has a
// valid/ready register that is loaded by a one-hot write strobe. Sticky
// flags report underrun, overrun and multi-hot strobes.
// Optional macro PROC_IO_SCHED_STAT_EN adds the frame_cnt port. frame_cnt
// counts frames, where a frame is complete once every channel has been
// popped at least once.
module proc_io_sched #(
  parameter int NCH = 4,
  parameter int DW  = 19,
  parameter int OW  = 28
) (
  input  logic           clk,
  input  logic           rst,
  proc_io_sched_if.slave bus
`ifdef PROC_IO_SCHED_STAT_EN
  ,
  output logic [15:0]    frame_cnt
`endif
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [DW-1:0]     r_fifo [NCH][2];
  logic [1:0]        r_cnt  [NCH];
  logic [DW-1:0]     r_hold [NCH];
  logic [NCH*OW-1:0] r_m_data;
  logic [NCH-1:0]    r_m_valid;
  logic [NCH-1:0]    r_underrun;
  logic [NCH-1:0]    r_overrun;
  logic              r_sel_err;

  logic [SW-1:0]  w_sel;
  logic [SW-1:0]  w_osel;
  logic           w_rd_any;
  logic           w_wr_any;
  logic           w_multi;
  logic           w_pop;
  logic [NCH-1:0] w_sel_vec;
  logic [NCH-1:0] w_osel_vec;
  logic [NCH-1:0] w_s_ready;
  logic [NCH-1:0] w_push;
  logic [NCH-1:0] w_pop_vec;
  logic [NCH-1:0] w_cap_vec;
  logic [NCH-1:0] w_und_set;
  logic [NCH-1:0] w_ovr_set;
  logic [DW-1:0]  w_io_in;

  // Lowest set bit wins for both strobes. The loop runs downward so that
  // the last assignment is the lowest index.
  always_comb begin
    w_sel  = '0;
    w_osel = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.req_in[i]) w_sel = SW'(i);
      if (bus.out_en[i]) w_osel = SW'(i);
    end
  end

  assign w_rd_any   = |bus.req_in;
  assign w_wr_any   = |bus.out_en;
  assign w_multi    = ((bus.req_in & (bus.req_in - 1'b1)) != '0) ||
                      ((bus.out_en & (bus.out_en - 1'b1)) != '0);
  assign w_sel_vec  = w_rd_any ? ({{(NCH-1){1'b0}}, 1'b1} << w_sel) : '0;
  assign w_osel_vec = w_wr_any ? ({{(NCH-1){1'b0}}, 1'b1} << w_osel) : '0;
  assign w_pop      = w_rd_any && (r_cnt[w_sel] != 2'd0);
  assign w_pop_vec  = w_pop ? w_sel_vec : '0;
  assign w_und_set  = (w_rd_any && !w_pop) ? w_sel_vec : '0;
  assign w_cap_vec  = w_osel_vec;
  assign w_ovr_set  = w_cap_vec & r_m_valid & ~bus.m_ready;

  // io_in is driven only by registered state, so a sample pushed in the
  // current cycle never reaches the processor in that same cycle.
  always_comb begin
    w_io_in = '0;
    if (w_rd_any) w_io_in = w_pop ? r_fifo[w_sel][0] : r_hold[w_sel];
  end

  // Ready is gated by rst so that upstream never sees ready during reset.
  always_comb begin
    w_s_ready = '0;
    w_push    = '0;
    for (int i = 0; i < NCH; i++) begin
      w_s_ready[i] = (r_cnt[i] < 2'd2) && rst;
      w_push[i]    = bus.s_valid[i] && w_s_ready[i];
    end
  end

  // Per-channel FIFO: entry 0 is the head. A pop shifts entry 1 forward,
  // and a push lands in the first slot that is free after that shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i]     <= '0;
        r_hold[i]    <= '0;
        r_fifo[i][0] <= '0;
        r_fifo[i][1] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_pop_vec[i]) begin
          r_hold[i]    <= r_fifo[i][0];
          r_fifo[i][0] <= r_fifo[i][1];
        end
        if (w_push[i]) begin
          if (w_pop_vec[i] || r_cnt[i] == 2'd0) r_fifo[i][0] <= bus.s_data[i*DW +: DW];
          else                                  r_fifo[i][1] <= bus.s_data[i*DW +: DW];
        end
        case ({w_push[i], w_pop_vec[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 2'd1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 2'd1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  // Output registers: a capture always loads the register, and a completed
  // handshake with no capture on that channel drops valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_data  <= '0;
      r_m_valid <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_cap_vec[i]) begin
          r_m_data[i*OW +: OW] <= bus.io_out;
          r_m_valid[i]         <= 1'b1;
        end else if (r_m_valid[i] && bus.m_ready[i]) begin
          r_m_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky flags: a set event in the same cycle as clr_flags wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_underrun <= '0;
      r_overrun  <= '0;
      r_sel_err  <= 1'b0;
    end else begin
      r_underrun <= (r_underrun & ~{NCH{bus.clr_flags}}) | w_und_set;
      r_overrun  <= (r_overrun  & ~{NCH{bus.clr_flags}}) | w_ovr_set;
      r_sel_err  <= (r_sel_err  & ~bus.clr_flags) | w_multi;
    end
  end

  assign bus.s_ready  = w_s_ready;
  assign bus.io_in    = w_io_in;
  assign bus.m_data   = r_m_data;
  assign bus.m_valid  = r_m_valid;
  assign bus.underrun = r_underrun;
  assign bus.overrun  = r_overrun;
  assign bus.sel_err  = r_sel_err;

`ifdef PROC_IO_SCHED_STAT_EN
  logic [NCH-1:0] r_mask;
  logic [15:0]    r_frame_cnt;
  logic [NCH-1:0] w_mask_nxt;

  assign w_mask_nxt = r_mask | w_pop_vec;

  // Only one pop can happen per cycle. A pop that repeats a channel already
  // in the mask leaves the mask unchanged, so the pop that completes a
  // frame is always the first pop of its channel and the mask clears
  // completely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask      <= '0;
      r_frame_cnt <= '0;
    end else if (&w_mask_nxt) begin
      r_mask      <= '0;
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end else begin
      r_mask <= w_mask_nxt;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif
endmodule

// File: tb/tb_proc_io_sched.sv
module tb_proc_io_sched;
  localparam int NCH = 4;
  localparam int DW  = 19;
  localparam int OW  = 28;

  typedef struct packed {
    logic [NCH-1:0] und;
    logic [NCH-1:0] ovr;
    logic           serr;
  } flags_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  proc_io_sched_if #(.NCH(NCH), .DW(DW), .OW(OW)) bus ();

`ifdef PROC_IO_SCHED_STAT_EN
  logic [15:0] frame_cnt;
  proc_io_sched #(.NCH(NCH), .DW(DW), .OW(OW)) dut (.clk(clk), .rst(rst), .bus(bus), .frame_cnt(frame_cnt));
  int m_mask;
  int m_frames;
`else
  proc_io_sched #(.NCH(NCH), .DW(DW), .OW(OW)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Reference model: the input FIFOs are queues, the output side is a queue
  // of values that are still awaiting a handshake on each channel.
  logic [DW-1:0] mq    [NCH][$];
  logic [DW-1:0] mhold [NCH];
  logic [OW-1:0] oq    [NCH][$];
  flags_t        e_fl;
  flags_t        pend;
  bit            pend_v;
  flags_t        flag_q [$];
  logic [DW-1:0] io_q   [$];
  logic [NCH-1:0] rdy_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT presented a value with no expectation at %0t", name, $time);
  endtask

  function automatic int lowbit(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [NCH*DW-1:0] mk(input int ch, input logic [DW-1:0] v);
    logic [NCH*DW-1:0] r;
    r = '0;
    r[ch*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [NCH-1:0] rand_strobe();
    int r;
    r = $urandom_range(0, 99);
    if (r < 40) return '0;
    if (r < 85) return NCH'(1) << $urandom_range(0, NCH - 1);
    return NCH'($urandom_range(0, (1 << NCH) - 1));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mq[i].delete();
      oq[i].delete();
      mhold[i] = '0;
    end
    e_fl = '0;
    pend_v = 1'b0;
    flag_q.delete();
    io_q.delete();
    rdy_q.delete();
`ifdef PROC_IO_SCHED_STAT_EN
    m_mask = 0;
    m_frames = 0;
`endif
  endtask

  // One clock cycle of stimulus. Drives the inputs at the falling edge and
  // records what the monitor should observe in this cycle and after the
  // next rising edge.
  task automatic step(input logic [NCH-1:0] req, input logic [NCH-1:0] oen,
                      input logic [NCH-1:0] sv, input logic [NCH*DW-1:0] sd,
                      input logic [NCH-1:0] mr, input logic [OW-1:0] iout,
                      input logic clr);
    logic [NCH-1:0] rdyv;
    flags_t         set;
    logic [DW-1:0]  v;
    int             s;
    @(negedge clk);
    bus.req_in = req; bus.out_en = oen; bus.s_valid = sv; bus.s_data = sd;
    bus.m_ready = mr; bus.io_out = iout; bus.clr_flags = clr;
    if (pend_v) flag_q.push_back(pend);
    for (int i = 0; i < NCH; i++) rdyv[i] = (mq[i].size() < 2);
    rdy_q.push_back(rdyv);
    set = '0;
    if (req != '0) begin
      s = lowbit(req);
      if ($countones(req) > 1) set.serr = 1'b1;
      if (mq[s].size() > 0) begin
        v = mq[s].pop_front();
        mhold[s] = v;
`ifdef PROC_IO_SCHED_STAT_EN
        m_mask = m_mask | (1 << s);
        if (m_mask == (1 << NCH) - 1) begin
          m_frames = (m_frames + 1) % 65536;
          m_mask = 0;
        end
`endif
      end else begin
        v = mhold[s];
        set.und[s] = 1'b1;
      end
      io_q.push_back(v);
    end
    for (int i = 0; i < NCH; i++)
      if (sv[i] && rdyv[i]) mq[i].push_back(sd[i*DW +: DW]);
    if (oen != '0) begin
      s = lowbit(oen);
      if ($countones(oen) > 1) set.serr = 1'b1;
      if (oq[s].size() > 0 && !mr[s]) begin
        set.ovr[s] = 1'b1;
        void'(oq[s].pop_back());
      end
      oq[s].push_back(iout);
    end
    if (clr) e_fl = '0;
    e_fl = e_fl | set;
    pend = e_fl;
    pend_v = 1'b1;
  endtask

  task automatic idle();
    step('0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  // Monitor: samples after the falling-edge stimulus settles and checks the
  // DUT against whatever the stimulus side queued.
  always @(negedge clk) begin
    flags_t f;
    #1;
    if (mon_en) begin
      if (rdy_q.size() > 0) check("s_ready", 64'(bus.s_ready), 64'(rdy_q.pop_front()));
      if (bus.req_in != '0) begin
        if (io_q.size() == 0) miss("io_in");
        else check("io_in", 64'(bus.io_in), 64'(io_q.pop_front()));
      end
      if (flag_q.size() > 0) begin
        f = flag_q.pop_front();
        check("underrun", 64'(bus.underrun), 64'(f.und));
        check("overrun", 64'(bus.overrun), 64'(f.ovr));
        check("sel_err", 64'(bus.sel_err), 64'(f.serr));
      end
      for (int i = 0; i < NCH; i++) begin
        if (bus.m_valid[i] && bus.m_ready[i]) begin
          if (oq[i].size() == 0) miss("m_valid");
          else check("m_data", 64'(bus.m_data[i*OW +: OW]), 64'(oq[i].pop_front()));
        end
      end
    end
  end

  initial begin
    logic [NCH*DW-1:0] sd;
    logic [31:0]       r32;
    bus.req_in = '0; bus.out_en = '0; bus.s_valid = '0; bus.s_data = '0;
    bus.m_ready = '0; bus.io_out = '0; bus.clr_flags = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    #2;
    check("rst_s_ready", 64'(bus.s_ready), 64'h0);
    check("rst_m_valid", 64'(bus.m_valid), 64'h0);
    check("rst_m_data", 64'(bus.m_data), 64'h0);
    check("rst_flags", 64'({bus.underrun, bus.overrun, bus.sel_err}), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    // Push and read on ch2.
    step('0, '0, 4'b0100, mk(2, 19'h00123), '0, '0, 1'b0);
    step(4'b0100, '0, '0, '0, '0, '0, 1'b0);
    // Fill ch0: the third push is held off, then two reads.
    step('0, '0, 4'b0001, mk(0, 19'h11), '0, '0, 1'b0);
    step('0, '0, 4'b0001, mk(0, 19'h22), '0, '0, 1'b0);
    step('0, '0, 4'b0001, mk(0, 19'h33), '0, '0, 1'b0);
    step(4'b0001, '0, '0, '0, '0, '0, 1'b0);
    step(4'b0001, '0, '0, '0, '0, '0, 1'b0);
    // Underrun on ch1 returns the held value, then clr_flags clears it.
    step('0, '0, 4'b0010, mk(1, 19'h7), '0, '0, 1'b0);
    step(4'b0010, '0, '0, '0, '0, '0, 1'b0);
    step(4'b0010, '0, '0, '0, '0, '0, 1'b0);
    step('0, '0, '0, '0, '0, '0, 1'b1);
    idle();
    // Overrun on ch0, then drain.
    step('0, 4'b0001, '0, '0, '0, 28'h0ABCDEF, 1'b0);
    step('0, 4'b0001, '0, '0, '0, 28'h1, 1'b0);
    step('0, '0, '0, '0, 4'b0001, '0, 1'b0);
    // Handshake and capture in the same cycle: no overrun.
    step('0, 4'b0010, '0, '0, '0, 28'h55, 1'b0);
    step('0, 4'b0010, '0, '0, 4'b0010, 28'h66, 1'b0);
    step('0, '0, '0, '0, 4'b0010, '0, 1'b0);
    // Multi-hot read: ch1 serviced, ch2 untouched.
    step('0, '0, 4'b0110, mk(1, 19'h1AA) | mk(2, 19'h2BB), '0, '0, 1'b1);
    step(4'b0110, '0, '0, '0, '0, '0, 1'b0);
    step(4'b0100, '0, '0, '0, '0, '0, 1'b0);
    step('0, 4'b1010, '0, '0, '0, 28'h0FEDCBA, 1'b1);
    step('0, '0, '0, '0, 4'b1111, '0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        r32 = $urandom;
        sd[c*DW +: DW] = r32[DW-1:0];
      end
      r32 = $urandom;
      step(rand_strobe(), rand_strobe(), NCH'($urandom_range(0, 15)), sd,
           NCH'($urandom_range(0, 15)), r32[OW-1:0], ($urandom_range(0, 19) == 0));
    end

    // Reset mid-transfer with ch3 full and m_valid[3] set.
    step('0, '0, 4'b1000, mk(3, 19'h3A), '0, '0, 1'b0);
    step('0, '0, 4'b1000, mk(3, 19'h3B), '0, '0, 1'b0);
    step('0, 4'b1000, '0, '0, '0, 28'h333, 1'b0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    bus.req_in = '0; bus.out_en = '0; bus.s_valid = '0; bus.m_ready = '0; bus.clr_flags = 1'b0;
    #1;
    check("mid_rst_s_ready", 64'(bus.s_ready), 64'h0);
    check("mid_rst_m_valid", 64'(bus.m_valid), 64'h0);
    check("mid_rst_flags", 64'({bus.underrun, bus.overrun, bus.sel_err}), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_s_ready", 64'(bus.s_ready), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    // Buffered data was discarded: ch3 reads back the cleared hold value.
    step(4'b1000, '0, '0, '0, '0, '0, 1'b0);
    step('0, '0, 4'b1000, mk(3, 19'h44), '0, '0, 1'b0);
    step(4'b1000, '0, '0, '0, '0, '0, 1'b0);

    // Drain outputs and flush pending flag checks.
    for (int n = 0; n < 4; n++) step('0, '0, '0, '0, '1, '0, 1'b0);
    #3;
    for (int i = 0; i < NCH; i++) check("out_drained", 64'(oq[i].size()), 64'h0);
    check("io_drained", 64'(io_q.size()), 64'h0);
`ifdef PROC_IO_SCHED_STAT_EN
    check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
